// File: rtl/dso100fb_layer_mix_pkg.sv
// Shared mode encoding and counter width for the dso100fb layer mixer.
package dso100fb_layer_mix_pkg;

    typedef enum logic [1:0] {
        MIX_OFF     = 2'b00,
        MIX_ADD     = 2'b01,
        MIX_ALPHA   = 2'b10,
        MIX_REPLACE = 2'b11
    } mix_mode_e;

    localparam int unsigned UNDERRUN_W = 16;

endpackage

// File: rtl/dso100fb_layer_mix_stage.sv
// One registered overlay stage: combines the incoming pixel with one layer pixel.
// DSO100FB_MIX_ALPHA_EN builds the alpha blender; without it alpha mode passes the pixel through.
module dso100fb_layer_mix_stage
    import dso100fb_layer_mix_pkg::*;
#(
    parameter int unsigned CW       = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic                   lyr_valid,
    input  logic [CHANNELS*CW-1:0] lyr_data,
    input  logic [CHANNELS*CW-1:0] pix_i,
    output logic [CHANNELS*CW-1:0] pix_o
);

    localparam int unsigned PW = CHANNELS * CW;

    logic          lyr_vld_q, lyr_vld_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [PW-1:0] lyr;
    logic          any_colour;
    logic [CW:0]   sum;

`ifdef DSO100FB_MIX_ALPHA_EN
    localparam int unsigned BW = 2 * CW + 1;
    localparam logic [CW:0] ALPHA_ONE = {1'b1, {CW{1'b0}}};
    logic [CW-1:0] alpha;
    logic [CW:0]   alpha_w;
    logic [BW-1:0] blend;
`endif

    // Layer data arrives the cycle after its valid strobe.
    always_comb begin
        lyr_vld_d  = lyr_valid;
        lyr        = lyr_vld_q ? lyr_data : '0;
        pix_d      = pix_i;
        sum        = '0;
        any_colour = 1'b0;
`ifdef DSO100FB_MIX_ALPHA_EN
        alpha      = lyr[PW-1 -: CW];
        alpha_w    = {1'b0, alpha} + (CW+1)'(alpha[CW-1]);
        blend      = '0;
`endif
        for (int c = 0; c < CHANNELS - 1; c++) begin
            any_colour = any_colour | (lyr[c*CW +: CW] != '0);
        end

        case (mix_mode_e'(mode))
            MIX_ADD: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    sum = {1'b0, pix_i[c*CW +: CW]} + {1'b0, lyr[c*CW +: CW]};
                    pix_d[c*CW +: CW] = sum[CW] ? '1 : sum[CW-1:0];
                end
            end
`ifdef DSO100FB_MIX_ALPHA_EN
            // Alpha is stretched to 0..2^CW so full alpha yields the layer exactly.
            MIX_ALPHA: begin
                for (int c = 0; c < CHANNELS - 1; c++) begin
                    blend = BW'(lyr[c*CW +: CW]) * BW'(alpha_w)
                          + BW'(pix_i[c*CW +: CW]) * BW'(ALPHA_ONE - alpha_w);
                    pix_d[c*CW +: CW] = CW'(blend >> CW);
                end
            end
`endif
            MIX_REPLACE: begin
                if (any_colour) pix_d = lyr;
            end
            default: pix_d = pix_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lyr_vld_q <= 1'b0;
            pix_q     <= '0;
        end else begin
            lyr_vld_q <= lyr_vld_d;
            pix_q     <= pix_d;
        end
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/dso100fb_layer_mix.sv
// Overlay mixer: base video plus LAYERS cascaded stages, frame-synchronous mode shadowing.
// Layer i is strobed i+1 cycles after the base fetch. Optional alpha blend: DSO100FB_MIX_ALPHA_EN.
module dso100fb_layer_mix
    import dso100fb_layer_mix_pkg::*;
#(
    parameter int unsigned LAYERS   = 2,
    parameter int unsigned CW       = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                          VIDCLK,
    input  logic                          RST_N,
    input  logic                          VIDEO_FETCH,
    input  logic                          VIDEO_EMPTY,
    input  logic [CHANNELS*CW-1:0]        VIDEO_DATA,
    input  logic [LAYERS-1:0]             LAYER_VALID,
    input  logic [LAYERS*CHANNELS*CW-1:0] LAYER_DATA,
    input  logic [2*LAYERS-1:0]           LAYER_MODE,
    input  logic                          DE,
    input  logic                          HSYNC,
    input  logic                          VSYNC,
    input  logic                          UNDERRUN_CLR,
    output logic [CHANNELS*CW-1:0]        VID_DATA,
    output logic                          VID_DE,
    output logic                          VID_HSYNC,
    output logic                          VID_VSYNC,
    output logic [2*LAYERS-1:0]           MODE_ACTIVE,
    output logic [UNDERRUN_W-1:0]         UNDERRUN_COUNT
);

    localparam int unsigned PW  = CHANNELS * CW;
    localparam int unsigned DLY = LAYERS + 2;

    logic                  fetch_q, fetch_d;
    logic [PW-1:0]         base_q, base_d;
    logic                  vsync_q, vsync_d;
    logic [2*LAYERS-1:0]   mode_q, mode_d;
    logic [DLY-1:0]        de_q, de_d;
    logic [DLY-1:0]        hs_q, hs_d;
    logic [DLY-1:0]        vs_q, vs_d;
    logic [UNDERRUN_W-1:0] ucnt_q, ucnt_d;
    logic [PW-1:0]         stage_pix [LAYERS+1];

    always_comb begin
        fetch_d = VIDEO_FETCH && !VIDEO_EMPTY;
        base_d  = fetch_q ? VIDEO_DATA : '0;
        vsync_d = VSYNC;
        mode_d  = mode_q;
        de_d    = {de_q[DLY-2:0], DE};
        hs_d    = {hs_q[DLY-2:0], HSYNC};
        vs_d    = {vs_q[DLY-2:0], VSYNC};
        ucnt_d  = ucnt_q;

        // Modes only change on a VSYNC rising edge so a frame is never mixed two ways.
        if (VSYNC && !vsync_q) mode_d = LAYER_MODE;

        if (UNDERRUN_CLR) begin
            ucnt_d = '0;
        end else if (DE && VIDEO_EMPTY && (ucnt_q != '1)) begin
            ucnt_d = ucnt_q + UNDERRUN_W'(1);
        end
    end

    always_ff @(posedge VIDCLK or negedge RST_N) begin
        if (!RST_N) begin
            fetch_q <= 1'b0;
            base_q  <= '0;
            vsync_q <= 1'b0;
            mode_q  <= '0;
            de_q    <= '0;
            hs_q    <= '0;
            vs_q    <= '0;
            ucnt_q  <= '0;
        end else begin
            fetch_q <= fetch_d;
            base_q  <= base_d;
            vsync_q <= vsync_d;
            mode_q  <= mode_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign stage_pix[0] = base_q;

    generate
        for (genvar i = 0; i < LAYERS; i++) begin : g_stage
            dso100fb_layer_mix_stage #(
                .CW       (CW),
                .CHANNELS (CHANNELS)
            ) u_stage (
                .clk       (VIDCLK),
                .rst_n     (RST_N),
                .mode      (mode_q[2*i +: 2]),
                .lyr_valid (LAYER_VALID[i]),
                .lyr_data  (LAYER_DATA[i*PW +: PW]),
                .pix_i     (stage_pix[i]),
                .pix_o     (stage_pix[i+1])
            );
        end
    endgenerate

    assign VID_DATA       = stage_pix[LAYERS];
    assign VID_DE         = de_q[DLY-1];
    assign VID_HSYNC      = hs_q[DLY-1];
    assign VID_VSYNC      = vs_q[DLY-1];
    assign MODE_ACTIVE    = mode_q;
    assign UNDERRUN_COUNT = ucnt_q;

endmodule

// File: tb/tb_dso100fb_layer_mix.sv
// Bench for dso100fb_layer_mix: directed and random stimulus against a cycle-history reference model.
module tb_dso100fb_layer_mix;

    localparam int L    = 2;
    localparam int CW   = 8;
    localparam int CH   = 4;
    localparam int PW   = CH * CW;
    localparam int RING = 16;
    localparam int FULL = 1 << CW;
    localparam int MAXV = FULL - 1;

    logic              VIDCLK = 1'b0;
    logic              RST_N;
    logic              VIDEO_FETCH, VIDEO_EMPTY;
    logic [PW-1:0]     VIDEO_DATA;
    logic [L-1:0]      LAYER_VALID;
    logic [L*PW-1:0]   LAYER_DATA;
    logic [2*L-1:0]    LAYER_MODE;
    logic              DE, HSYNC, VSYNC, UNDERRUN_CLR;
    logic [PW-1:0]     VID_DATA;
    logic              VID_DE, VID_HSYNC, VID_VSYNC;
    logic [2*L-1:0]    MODE_ACTIVE;
    logic [15:0]       UNDERRUN_COUNT;

    dso100fb_layer_mix #(.LAYERS(L), .CW(CW), .CHANNELS(CH)) dut (
        .VIDCLK         (VIDCLK),
        .RST_N          (RST_N),
        .VIDEO_FETCH    (VIDEO_FETCH),
        .VIDEO_EMPTY    (VIDEO_EMPTY),
        .VIDEO_DATA     (VIDEO_DATA),
        .LAYER_VALID    (LAYER_VALID),
        .LAYER_DATA     (LAYER_DATA),
        .LAYER_MODE     (LAYER_MODE),
        .DE             (DE),
        .HSYNC          (HSYNC),
        .VSYNC          (VSYNC),
        .UNDERRUN_CLR   (UNDERRUN_CLR),
        .VID_DATA       (VID_DATA),
        .VID_DE         (VID_DE),
        .VID_HSYNC      (VID_HSYNC),
        .VID_VSYNC      (VID_VSYNC),
        .MODE_ACTIVE    (MODE_ACTIVE),
        .UNDERRUN_COUNT (UNDERRUN_COUNT)
    );

    always #5 VIDCLK = ~VIDCLK;

    // Per-cycle input history, indexed by cycle number modulo RING.
    logic            h_fetch [RING];
    logic [PW-1:0]   h_vdata [RING];
    logic [L-1:0]    h_lv    [RING];
    logic [L*PW-1:0] h_ld    [RING];
    logic [2*L-1:0]  h_mode  [RING];
    logic            h_de    [RING];
    logic            h_hs    [RING];
    logic            h_vs    [RING];

    int             cyc;
    int             n_cmp;
    int             n_bad;
    int             ucnt_m;
    logic           vs_prev_m;
    logic [2*L-1:0] mode_m;

    function automatic int idx(input int n);
        return ((n % RING) + RING) % RING;
    endfunction

    function automatic logic [PW-1:0] mix_px(input logic [PW-1:0] p, input logic [PW-1:0] l,
                                            input logic [1:0] m);
        logic [PW-1:0] o;
        int            pc, lc, s;
        bit            nz;
`ifdef DSO100FB_MIX_ALPHA_EN
        int            a;
        a = int'(l[PW-1 -: CW]);
        a = a + ((a >= FULL / 2) ? 1 : 0);
`endif
        o  = p;
        nz = 1'b0;
        for (int c = 0; c < CH - 1; c++) if (l[c*CW +: CW] != '0) nz = 1'b1;
        for (int c = 0; c < CH; c++) begin
            pc = int'(p[c*CW +: CW]);
            lc = int'(l[c*CW +: CW]);
            s  = pc + lc;
            if (m == 2'b01) o[c*CW +: CW] = CW'((s > MAXV) ? MAXV : s);
`ifdef DSO100FB_MIX_ALPHA_EN
            else if (m == 2'b10 && c < CH - 1) o[c*CW +: CW] = CW'((lc * a + pc * (FULL - a)) / FULL);
`endif
            else if (m == 2'b11 && nz) o[c*CW +: CW] = l[c*CW +: CW];
        end
        return o;
    endfunction

    // Output at cycle n: base fetched at n-L-2, layer i strobed at n-L+i-1, mode seen at n-L+i.
    function automatic logic [PW-1:0] exp_out(input int n);
        logic [PW-1:0]  p, lpx;
        logic [2*L-1:0] mv;
        p = h_fetch[idx(n - L - 2)] ? h_vdata[idx(n - L - 1)] : '0;
        for (int i = 0; i < L; i++) begin
            lpx = h_lv[idx(n - L + i - 1)][i] ? h_ld[idx(n - L + i)][i*PW +: PW] : '0;
            mv  = h_mode[idx(n - L + i)];
            p   = mix_px(p, lpx, mv[2*i +: 2]);
        end
        return p;
    endfunction

    function automatic logic [CW-1:0] rchan();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            2:       return CW'(FULL / 2);
            default: return CW'($urandom);
        endcase
    endfunction

    function automatic logic [PW-1:0] rpix();
        logic [PW-1:0] v;
        for (int c = 0; c < CH; c++) v[c*CW +: CW] = rchan();
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < RING; i++) begin
            h_fetch[i] = 1'b0; h_vdata[i] = '0; h_lv[i] = '0; h_ld[i] = '0;
            h_mode[i]  = '0;   h_de[i]    = 1'b0; h_hs[i] = 1'b0; h_vs[i] = 1'b0;
        end
        mode_m    = '0;
        vs_prev_m = 1'b0;
        ucnt_m    = 0;
    endtask

    task automatic idle();
        VIDEO_FETCH = 1'b0; VIDEO_EMPTY = 1'b0; VIDEO_DATA = '0;
        LAYER_VALID = '0;   LAYER_DATA  = '0;
        DE = 1'b0; HSYNC = 1'b0; VSYNC = 1'b0; UNDERRUN_CLR = 1'b0;
    endtask

    // Record this cycle's inputs, advance one clock, check every output against the model.
    task automatic step();
        int k;
        k = idx(cyc);
        h_fetch[k] = VIDEO_FETCH && !VIDEO_EMPTY;
        h_vdata[k] = VIDEO_DATA;
        h_lv[k]    = LAYER_VALID;
        h_ld[k]    = LAYER_DATA;
        h_mode[k]  = mode_m;
        h_de[k]    = DE;
        h_hs[k]    = HSYNC;
        h_vs[k]    = VSYNC;
        if (VSYNC && !vs_prev_m) mode_m = LAYER_MODE;
        vs_prev_m = VSYNC;
        if (UNDERRUN_CLR) ucnt_m = 0;
        else if (DE && VIDEO_EMPTY && ucnt_m < 65535) ucnt_m++;
        @(posedge VIDCLK);
        #1;
        cyc++;
        chk("vid_data",    64'(VID_DATA),       64'(exp_out(cyc)));
        chk("vid_de",      64'(VID_DE),         64'(h_de[idx(cyc - L - 2)]));
        chk("vid_hsync",   64'(VID_HSYNC),      64'(h_hs[idx(cyc - L - 2)]));
        chk("vid_vsync",   64'(VID_VSYNC),      64'(h_vs[idx(cyc - L - 2)]));
        chk("mode_active", 64'(MODE_ACTIVE),    64'(mode_m));
        chk("underrun",    64'(UNDERRUN_COUNT), 64'(ucnt_m));
    endtask

    task automatic load_modes(input logic [2*L-1:0] m);
        idle();
        step();
        LAYER_MODE = m;
        VSYNC      = 1'b1;
        step();
        VSYNC      = 1'b0;
        step();
    endtask

    // Fetch a base pixel with DE, then strobe each layer on its own cycle.
    task automatic drive_px(input logic [PW-1:0] base, input logic [L*PW-1:0] ld);
        for (int j = 0; j <= L + 1; j++) begin
            idle();
            VIDEO_FETCH = (j == 0);
            DE          = (j == 0);
            VIDEO_DATA  = (j == 1) ? base : '0;
            for (int i = 0; i < L; i++) begin
                LAYER_VALID[i]        = (j == i + 1);
                LAYER_DATA[i*PW +: PW] = (j == i + 2) ? ld[i*PW +: PW] : '0;
            end
            step();
        end
    endtask

    task automatic rand_cycle();
        VIDEO_FETCH  = 1'($urandom_range(0, 1));
        VIDEO_EMPTY  = ($urandom_range(0, 3) == 0);
        VIDEO_DATA   = rpix();
        LAYER_VALID  = L'($urandom);
        for (int i = 0; i < L; i++) LAYER_DATA[i*PW +: PW] = rpix();
        LAYER_MODE   = (2*L)'($urandom);
        DE           = 1'($urandom_range(0, 1));
        HSYNC        = 1'($urandom_range(0, 1));
        VSYNC        = ($urandom_range(0, 5) == 0);
        UNDERRUN_CLR = ($urandom_range(0, 15) == 0);
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        RST_N = 1'b0;
        LAYER_MODE = '0;
        idle();
        clear_model();
        @(posedge VIDCLK);
        @(posedge VIDCLK);
        #1;
        chk("reset_data",  64'(VID_DATA),       64'(0));
        chk("reset_de",    64'(VID_DE),         64'(0));
        chk("reset_mode",  64'(MODE_ACTIVE),    64'(0));
        chk("reset_ucnt",  64'(UNDERRUN_COUNT), 64'(0));
        RST_N = 1'b1;

        // Saturating add on layer 0, layer 1 off; result lands L+2 cycles after fetch.
        load_modes(4'b0001);
        drive_px(32'h10F0_8040, {32'h0, 32'h2020_0040});
        chk("add_data", 64'(VID_DATA), 64'(32'h30FF_8080));
        chk("add_de",   64'(VID_DE),   64'(1));

`ifdef DSO100FB_MIX_ALPHA_EN
        load_modes(4'b0010);
        drive_px(32'h0, {32'h0, 32'hFF12_3456});
        chk("alpha_full", 64'(VID_DATA), 64'(32'h0012_3456));
        drive_px(32'h0, {32'h0, 32'h0012_3456});
        chk("alpha_zero", 64'(VID_DATA), 64'(32'h0));
        drive_px(32'h0, {32'h0, 32'h80FF_FFFF});
        chk("alpha_half", 64'(VID_DATA), 64'(32'h0080_8080));
`else
        load_modes(4'b1010);
        drive_px(32'h1122_3344, {32'h8080_8080, 32'hFF00_FF00});
        chk("alpha_off_pass", 64'(VID_DATA), 64'(32'h1122_3344));
`endif

        // Mid-frame mode change is ignored until VSYNC rises.
        load_modes(4'b0101);
        LAYER_MODE = 4'b0000;
        drive_px(32'h0102_0304, {32'h1010_1010, 32'h2020_2020});
        chk("shadow_hold", 64'(MODE_ACTIVE), 64'(4'b0101));
        idle();
        VSYNC = 1'b1;
        step();
        chk("shadow_load", 64'(MODE_ACTIVE), 64'(4'b0000));
        VSYNC = 1'b0;
        drive_px(32'h0102_0304, {32'h1010_1010, 32'h2020_2020});
        chk("shadow_off_data", 64'(VID_DATA), 64'(32'h0102_0304));

        for (int n = 0; n < 1500; n++) rand_cycle();

        // Underrun counting, saturation and clear priority.
        idle();
        UNDERRUN_CLR = 1'b1;
        step();
        UNDERRUN_CLR = 1'b0;
        DE           = 1'b1;
        VIDEO_EMPTY  = 1'b1;
        for (int n = 0; n < 5; n++) step();
        chk("underrun_5", 64'(UNDERRUN_COUNT), 64'(5));
        for (int n = 0; n < 65535; n++) step();
        chk("underrun_sat", 64'(UNDERRUN_COUNT), 64'(16'hFFFF));
        UNDERRUN_CLR = 1'b1;
        step();
        chk("underrun_clr", 64'(UNDERRUN_COUNT), 64'(0));

        // Asynchronous reset with the pipeline full.
        load_modes(4'b1111);
        for (int n = 0; n < 6; n++) begin
            idle();
            VIDEO_FETCH = 1'b1;
            VIDEO_DATA  = 32'hA5A5_A5A5;
            LAYER_VALID = '1;
            LAYER_DATA  = {32'h0F0F_0F0F, 32'h0303_0303};
            DE = 1'b1; HSYNC = 1'b1; VSYNC = 1'b0; VIDEO_EMPTY = 1'b1;
            step();
        end
        RST_N = 1'b0;
        #1;
        chk("rst_data",  64'(VID_DATA),       64'(0));
        chk("rst_de",    64'(VID_DE),         64'(0));
        chk("rst_hsync", 64'(VID_HSYNC),      64'(0));
        chk("rst_mode",  64'(MODE_ACTIVE),    64'(0));
        chk("rst_ucnt",  64'(UNDERRUN_COUNT), 64'(0));
        clear_model();
        idle();
        LAYER_MODE = 4'b0110;
        VSYNC      = 1'b1;
        RST_N      = 1'b1;
        step();
        chk("rst_vsync_load", 64'(MODE_ACTIVE), 64'(4'b0110));

        for (int n = 0; n < 300; n++) rand_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
